pn_arbiter: RTL and testbench

PN_ARBITER -- requirements
Module: pn_arbiter

---
 rtl/pn_arbiter.sv | 178 +++++++++++++++++
 tb/tb_pn_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pn_arbiter.sv
// Round-robin arbiter that grants one of four lanes access to a shared PN evaluator,
// streams the lane's tokens to the engine and returns the engine's result beats to that lane.
module pn_arbiter #(
    parameter int START_MAX = 15,
    parameter int WAIT_MAX  = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [7:0]         req_mode,
    input  logic [3:0]         req_operator,
    input  logic [11:0]        req_in,
    input  logic [3:0]         req_in_valid,
    output logic [3:0]         gnt,
    output logic [1:0]         eng_mode,
    output logic               eng_operator,
    output logic [2:0]         eng_in,
    output logic               eng_in_valid,
    input  logic               eng_out_valid,
    input  logic signed [31:0] eng_out,
    output logic               out_valid,
    output logic signed [31:0] out,
    output logic [1:0]         out_id,
    output logic               busy,
    output logic               err
);

    localparam int START_W = $clog2(START_MAX + 1);
    localparam int WAIT_W  = $clog2(WAIT_MAX + 1);
    localparam logic [START_W-1:0] START_LAST = START_W'(START_MAX - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(WAIT_MAX - 1);
    localparam logic [3:0]         TOK_MAX    = 4'd12;

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_WAIT} state_t;

    state_t             state, next_state;
    logic [1:0]         last, gnt_idx, pick;
    logic [3:0]         tok_cnt;
    logic [START_W-1:0] start_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               seen_beat;
    logic               take_grant, fwd, drop_err, timeout, release_gnt;
    logic               lane_valid, lane_op;
    logic [2:0]         lane_in;
    logic [1:0]         lane_mode;

    assign lane_valid = req_in_valid[gnt_idx];
    assign lane_op    = req_operator[gnt_idx];
    assign lane_in    = req_in[int'(gnt_idx) * 3 +: 3];
    assign lane_mode  = req_mode[int'(gnt_idx) * 2 +: 2];
    assign busy       = (state != ST_IDLE);

    // Offsets are scanned farthest-first so the nearest requester after 'last' is the final write.
    always_comb begin
        logic [1:0] cand;
        pick = '0;
        for (int i = 4; i >= 1; i--) begin
            cand = last + 2'(i);
            if (req[cand]) pick = cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        next_state  = state;
        take_grant  = 1'b0;
        fwd         = 1'b0;
        drop_err    = 1'b0;
        timeout     = 1'b0;
        release_gnt = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (|req) begin
                    take_grant = 1'b1;
                    next_state = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (lane_valid) begin
                    if (tok_cnt < TOK_MAX)       fwd      = 1'b1;
                    else if (tok_cnt == TOK_MAX) drop_err = 1'b1;
                end else if (tok_cnt != 4'd0) begin
                    next_state = ST_WAIT;
                end else if (start_cnt == START_LAST) begin
                    timeout     = 1'b1;
                    release_gnt = 1'b1;
                    next_state  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!eng_out_valid) begin
                    if (seen_beat) begin
                        release_gnt = 1'b1;
                        next_state  = ST_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout     = 1'b1;
                        release_gnt = 1'b1;
                        next_state  = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last         <= 2'd3;
            gnt          <= '0;
            gnt_idx      <= '0;
            tok_cnt      <= '0;
            start_cnt    <= '0;
            wait_cnt     <= '0;
            seen_beat    <= 1'b0;
            eng_mode     <= '0;
            eng_operator <= 1'b0;
            eng_in       <= '0;
            eng_in_valid <= 1'b0;
            out_valid    <= 1'b0;
            out          <= '0;
            out_id       <= '0;
            err          <= 1'b0;
        end else begin
            err <= drop_err | timeout;

            if (take_grant) begin
                gnt       <= 4'b0001 << pick;
                gnt_idx   <= pick;
                tok_cnt   <= '0;
                start_cnt <= '0;
            end

            if (release_gnt) begin
                gnt          <= '0;
                last         <= gnt_idx;
                eng_mode     <= '0;
                eng_operator <= 1'b0;
                eng_in       <= '0;
            end

            if (state == ST_STREAM) begin
                eng_in_valid <= fwd;
                if (fwd) begin
                    eng_operator <= lane_op;
                    eng_in       <= lane_in;
                    tok_cnt      <= tok_cnt + 4'd1;
                    if (tok_cnt == 4'd0) eng_mode <= lane_mode;
                end
                // Parking the counter one past the limit makes the drop error fire exactly once.
                if (drop_err) tok_cnt <= TOK_MAX + 4'd1;
                if (!lane_valid && tok_cnt == 4'd0) start_cnt <= start_cnt + START_W'(1);
                wait_cnt  <= '0;
                seen_beat <= 1'b0;
            end else begin
                eng_in_valid <= 1'b0;
            end

            if (state == ST_WAIT) begin
                out_valid <= eng_out_valid;
                out       <= eng_out_valid ? eng_out : '0;
                out_id    <= eng_out_valid ? gnt_idx : '0;
                if (eng_out_valid) seen_beat <= 1'b1;
                else               wait_cnt  <= wait_cnt + WAIT_W'(1);
            end else begin
                out_valid <= 1'b0;
                out       <= '0;
                out_id    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pn_arbiter.sv
// Directed bench for pn_arbiter: stimulus pushes expected engine tokens and result beats
// into queues, and negedge monitors pop and compare whenever the DUT presents them.
module tb_pn_arbiter;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         req;
    logic [7:0]         req_mode;
    logic [3:0]         req_operator;
    logic [11:0]        req_in;
    logic [3:0]         req_in_valid;
    logic [3:0]         gnt;
    logic [1:0]         eng_mode;
    logic               eng_operator;
    logic [2:0]         eng_in;
    logic               eng_in_valid;
    logic               eng_out_valid;
    logic signed [31:0] eng_out;
    logic               out_valid;
    logic signed [31:0] out;
    logic [1:0]         out_id;
    logic               busy;
    logic               err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] mode;
        logic       op;
        logic [2:0] tok;
    } tok_t;

    typedef struct {
        logic [31:0] val;
        logic [1:0]  id;
    } res_t;

    tok_t exp_tok[$];
    res_t exp_res[$];

    pn_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_mode(req_mode),
        .req_operator(req_operator), .req_in(req_in), .req_in_valid(req_in_valid),
        .gnt(gnt), .eng_mode(eng_mode), .eng_operator(eng_operator), .eng_in(eng_in),
        .eng_in_valid(eng_in_valid), .eng_out_valid(eng_out_valid), .eng_out(eng_out),
        .out_valid(out_valid), .out(out), .out_id(out_id), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_token(input int lane, input logic [1:0] mode, input logic op,
                             input logic [2:0] tok, input logic [1:0] exp_mode, input bit fwd);
        req_in_valid             = 4'b0001 << lane;
        req_mode[2*lane +: 2]    = mode;
        req_operator             = 4'b0000;
        req_operator[lane]       = op;
        req_in[3*lane +: 3]      = tok;
        if (fwd) exp_tok.push_back('{mode: exp_mode, op: op, tok: tok});
        tick();
    endtask

    task automatic end_tokens();
        req_in_valid = 4'b0000;
        tick();
    endtask

    task automatic beat(input logic signed [31:0] val, input logic [1:0] id, input bit expect_out);
        eng_out_valid = 1'b1;
        eng_out       = val;
        if (expect_out) exp_res.push_back('{val: val, id: id});
        tick();
    endtask

    task automatic eng_idle();
        eng_out_valid = 1'b0;
        eng_out       = '0;
        tick();
    endtask

    always @(negedge clk) begin : mon_tok
        tok_t t;
        if (rst_n && eng_in_valid) begin
            if (exp_tok.size() == 0) begin
                check("eng_unexpected_token", 32'(eng_in_valid), 32'(0));
            end else begin
                t = exp_tok.pop_front();
                check("eng_mode", 32'(eng_mode), 32'(t.mode));
                check("eng_operator", 32'(eng_operator), 32'(t.op));
                check("eng_in", 32'(eng_in), 32'(t.tok));
            end
        end
    end

    always @(negedge clk) begin : mon_res
        res_t r;
        if (rst_n) begin
            if (out_valid) begin
                if (exp_res.size() == 0) begin
                    check("out_unexpected_beat", 32'(out_valid), 32'(0));
                end else begin
                    r = exp_res.pop_front();
                    check("out", out, r.val);
                    check("out_id", 32'(out_id), 32'(r.id));
                end
            end else begin
                check("out_zero_when_idle", 32'(out) | 32'(out_id), 32'(0));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic err_seen;
        rst_n         = 1'b0;
        req           = '0;
        req_mode      = '0;
        req_operator  = '0;
        req_in        = '0;
        req_in_valid  = '0;
        eng_out_valid = 1'b0;
        eng_out       = '0;
        #12;
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_eng_in_valid", 32'(eng_in_valid), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Lane 2 alone: postfix 3 4 + evaluates to 7.
        req = 4'b0100;
        tick();
        check("t1_gnt", 32'(gnt), 32'(4'b0100));
        check("t1_busy", 32'(busy), 32'(1));
        req = 4'b0000;
        put_token(2, 2'd3, 1'b0, 3'd3, 2'd3, 1'b1);
        put_token(2, 2'd3, 1'b0, 3'd4, 2'd3, 1'b1);
        put_token(2, 2'd3, 1'b1, 3'd0, 2'd3, 1'b1);
        end_tokens();
        check("t1_gnt_held", 32'(gnt), 32'(4'b0100));
        beat(7, 2'd2, 1'b1);
        eng_idle();
        check("t1_gnt_released", 32'(gnt), 32'(0));
        check("t1_busy_released", 32'(busy), 32'(0));
        beat(99, 2'd0, 1'b0);
        check("t1_late_beat_ignored", 32'(out_valid), 32'(0));
        eng_idle();

        // Fresh reset so round-robin starts at lane 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            check("t2_idle_between", 32'(gnt), 32'(0));
            tick();
            check("t2_gnt_order", 32'(gnt), 32'(4'b0001 << k));
            put_token(k, 2'(k), 1'b0, 3'(k + 1), 2'(k), 1'b1);
            end_tokens();
            beat(100 + k, 2'(k), 1'b1);
            eng_idle();
        end
        req = 4'b0000;

        // Lane 0 mode 0, two triples; a later lane-mode change must not reach eng_mode.
        req = 4'b0001;
        tick();
        check("t3_gnt", 32'(gnt), 32'(4'b0001));
        req = 4'b0000;
        put_token(0, 2'd0, 1'b1, 3'd0, 2'd0, 1'b1);
        put_token(0, 2'd3, 1'b0, 3'd2, 2'd0, 1'b1);
        put_token(0, 2'd3, 1'b0, 3'd3, 2'd0, 1'b1);
        put_token(0, 2'd3, 1'b1, 3'd2, 2'd0, 1'b1);
        put_token(0, 2'd3, 1'b0, 3'd2, 2'd0, 1'b1);
        put_token(0, 2'd3, 1'b0, 3'd5, 2'd0, 1'b1);
        end_tokens();
        beat(10, 2'd0, 1'b1);
        beat(5, 2'd0, 1'b1);
        eng_idle();
        check("t3_gnt_released", 32'(gnt), 32'(0));

        // Lane 1 granted but silent: start timeout, then lane 2 wins.
        req = 4'b0110;
        tick();
        check("t4_gnt", 32'(gnt), 32'(4'b0010));
        err_seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            err_seen |= err;
        end
        check("t4_no_early_err", 32'(err_seen), 32'(0));
        tick();
        check("t4_err_pulse", 32'(err), 32'(1));
        check("t4_gnt_revoked", 32'(gnt), 32'(0));
        tick();
        check("t4_err_one_cycle", 32'(err), 32'(0));
        check("t4_next_gnt", 32'(gnt), 32'(4'b0100));
        req = 4'b0000;

        // Lane 2 streams a token, engine stays silent: WAIT timeout.
        put_token(2, 2'd1, 1'b0, 3'd5, 2'd1, 1'b1);
        end_tokens();
        err_seen = 1'b0;
        for (int i = 0; i < 254; i++) begin
            tick();
            err_seen |= err;
        end
        check("t5_no_early_err", 32'(err_seen), 32'(0));
        check("t5_busy_waiting", 32'(busy), 32'(1));
        tick();
        check("t5_err_pulse", 32'(err), 32'(1));
        check("t5_gnt_revoked", 32'(gnt), 32'(0));
        check("t5_busy_idle", 32'(busy), 32'(0));

        // Lane 3 sends 14 tokens: 12 forwarded, err on the 13th.
        req = 4'b1000;
        tick();
        check("t6_gnt", 32'(gnt), 32'(4'b1000));
        req = 4'b0000;
        for (int i = 0; i < 14; i++) begin
            put_token(3, 2'd1, 1'b0, 3'(i), 2'd1, i < 12);
            check("t6_err", 32'(err), 32'(i == 12));
        end
        end_tokens();
        beat(-3, 2'd3, 1'b1);
        eng_idle();
        check("t6_gnt_released", 32'(gnt), 32'(0));

        // Reset in the middle of a stream.
        req = 4'b0001;
        tick();
        check("t7_gnt", 32'(gnt), 32'(4'b0001));
        put_token(0, 2'd2, 1'b0, 3'd1, 2'd2, 1'b1);
        put_token(0, 2'd2, 1'b0, 3'd2, 2'd2, 1'b1);
        rst_n = 1'b0;
        req = 4'b0000;
        req_in_valid = 4'b0000;
        #1;
        exp_tok.delete();
        check("t7_gnt", 32'(gnt), 32'(0));
        check("t7_eng", 32'({eng_mode, eng_operator, eng_in, eng_in_valid}), 32'(0));
        check("t7_out", 32'(out) | 32'({out_valid, out_id}), 32'(0));
        check("t7_busy", 32'(busy), 32'(0));
        check("t7_err", 32'(err), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();
        check("t7_no_err_after", 32'(err), 32'(0));
        check("t7_idle_after", 32'(busy), 32'(0));

        tick();
        check("tok_queue_drained", 32'(exp_tok.size()), 32'(0));
        check("res_queue_drained", 32'(exp_res.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
